fp8_add_sequencer: RTL and testbench

Command sequencer for the 8-bit floating-point adder datapath. Accepts byte-wide operands and commands from slow, asynchronous chip pins, holds operand registers A and B, launches the adder and waits a fixed latency. It then captures the sum into a result register that the top-level maps to the output/segment pins, and supports an accumulate mode that feeds each sum back as operand A.

---
 rtl/fp8_ctrl_pkg.sv | 25 ++
 rtl/pin_strobe_sync.sv | 40 ++++
 rtl/fp8_add_sequencer.sv | 147 ++++++++++++++
 tb/tb_fp8_add_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_ctrl_pkg.sv
// Shared types and constants for the fp8 adder control path.
package fp8_ctrl_pkg;

  // Operand and result byte width.
  localparam int FP8_W = 8;

  // Launch-latency counter width; covers ADD_LATENCY values 0..7.
  localparam int CNT_W = 3;

  // Pin command codes as driven on the cmd pins.
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    ADD    = 2'b10,
    ACC    = 2'b11
  } cmd_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : fp8_ctrl_pkg

// File: rtl/pin_strobe_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous pin strobe. Produces a single-cycle pulse per pin rise.
// The previous-value flop freezes with ena, so a rise that arrives while
// the design is disabled is reported exactly once after ena returns.
module pin_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic pin,
  output logic pulse
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Synchronizer chain keeps tracking the pin even while ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= pin;
      sync_reg <= meta_reg;
    end
  end

  // Previous synchronized level, held while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg <= 1'b0;
    end else if (ena) begin
      prev_reg <= sync_reg;
    end
  end

  // Pulse is suppressed while disabled; the held prev_reg keeps the edge pending.
  assign pulse = ena & sync_reg & ~prev_reg;

endmodule : pin_strobe_sync

// File: rtl/fp8_add_sequencer.sv
// Command sequencer for the external 8-bit floating-point adder.
// Loads operands from the pins, launches the adder, waits a fixed latency,
// captures the sum and optionally feeds it back as operand A (accumulate).
module fp8_add_sequencer
  import fp8_ctrl_pkg::*;
#(
  parameter int ADD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [FP8_W-1:0] data_in,
  input  logic [1:0]       cmd,
  input  logic             strb,
  output logic [FP8_W-1:0] add_a,
  output logic [FP8_W-1:0] add_b,
  output logic             add_go,
  input  logic [FP8_W-1:0] add_sum,
  output logic [FP8_W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             dropped
);

  // Counter reload value; the counter equals this only in the first RUN cycle.
  localparam logic [CNT_W-1:0] LAT = CNT_W'(ADD_LATENCY);

  logic             cmd_ev;
  cmd_e             cmd_code;

  state_e           state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [FP8_W-1:0] a_reg,       a_next;
  logic [FP8_W-1:0] b_reg,       b_next;
  logic [FP8_W-1:0] result_reg,  result_next;
  logic             acc_reg,     acc_next;
  logic             dropped_reg, dropped_next;

  pin_strobe_sync u_strb_sync (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .pin   (strb),
    .pulse (cmd_ev)
  );

  // cmd is only guaranteed stable around the strobe, so it is decoded only when cmd_ev fires.
  assign cmd_code = cmd_e'(cmd);

  // State, counter, operand and flag registers; everything holds while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      acc_reg     <= 1'b0;
      dropped_reg <= 1'b0;
    end else if (ena) begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      result_reg  <= result_next;
      acc_reg     <= acc_next;
      dropped_reg <= dropped_next;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    result_next  = result_reg;
    acc_next     = acc_reg;
    dropped_next = dropped_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_ev) begin
          case (cmd_code)
            LOAD_A: begin
              a_next       = data_in;
              dropped_next = 1'b0;
            end
            LOAD_B: begin
              b_next = data_in;
            end
            ADD: begin
              state_next = RUN;
              cnt_next   = LAT;
            end
            ACC: begin
              b_next     = data_in;
              acc_next   = 1'b1;
              state_next = RUN;
              cnt_next   = LAT;
            end
            default: begin
              state_next = IDLE;
            end
          endcase
        end
      end

      RUN: begin
        if (cmd_ev) begin
          dropped_next = 1'b1;
        end
        if (cnt_reg == '0) begin
          result_next = add_sum;
          if (acc_reg) begin
            a_next   = add_sum;
            acc_next = 1'b0;
          end
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      DONE: begin
        if (cmd_ev) begin
          dropped_next = 1'b1;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs come from registers or the decoded state; the pulses are masked while disabled.
  assign add_a   = a_reg;
  assign add_b   = b_reg;
  assign result  = result_reg;
  assign dropped = dropped_reg;
  assign busy    = (state_reg != IDLE);
  assign add_go  = ena && (state_reg == RUN) && (cnt_reg == LAT);
  assign done    = ena && (state_reg == DONE);

endmodule : fp8_add_sequencer

// File: tb/tb_fp8_add_sequencer.sv
// Bench for fp8_add_sequencer: three instances (latency 1, 7, 0) share one
// stimulus stream; a transaction-level model predicts every output each cycle.
module tb_fp8_add_sequencer;

  localparam int ND = 3;
  localparam int LATS [ND] = '{1, 7, 0};
  localparam logic [1:0] C_LDA = 2'b00, C_LDB = 2'b01, C_ADD = 2'b10, C_ACC = 2'b11;

  typedef struct {
    int         edge_n;
    logic [1:0] c;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       strb = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] cmd = 2'b00;

  logic [7:0] add_a_w [ND];
  logic [7:0] add_b_w [ND];
  logic [7:0] add_sum_w [ND];
  logic [7:0] result_w [ND];
  logic       add_go_w [ND];
  logic       busy_w [ND];
  logic       done_w [ND];
  logic       dropped_w [ND];

  ev_t evq[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int go_cyc [ND];
  int done_cyc [ND];
  int go_cnt [ND];
  int done_cnt [ND];

  // Model state: operands, result, sticky flag, pending accumulate, and the
  // number of enabled cycles left in the current launch (0 = idle).
  int m_a [ND];
  int m_b [ND];
  int m_res [ND];
  int m_rem [ND];
  bit m_acc [ND];
  bit m_drop [ND];
  bit prev_rst = 1'b1;
  bit prev_ena = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int L = LATS[gi];
    logic [7:0] pipe [8];

    fp8_add_sequencer #(.ADD_LATENCY(L)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .data_in (data_in),
      .cmd     (cmd),
      .strb    (strb),
      .add_a   (add_a_w[gi]),
      .add_b   (add_b_w[gi]),
      .add_go  (add_go_w[gi]),
      .add_sum (add_sum_w[gi]),
      .result  (result_w[gi]),
      .busy    (busy_w[gi]),
      .done    (done_w[gi]),
      .dropped (dropped_w[gi])
    );

    // Stub adder: (a+b) mod 256 delayed by L cycles.
    always @(posedge clk) begin
      pipe[0] <= add_a_w[gi] + add_b_w[gi];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    if (L == 0) begin : g_comb
      assign add_sum_w[gi] = add_a_w[gi] + add_b_w[gi];
    end else begin : g_pipe
      assign add_sum_w[gi] = pipe[L-1];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Raise the strobe with cmd/data, hold 4 cycles, drop it, then idle gap cycles.
  // The command takes effect at the third edge after the rise.
  task automatic issue(input logic [1:0] c, input logic [7:0] d, input int gap, output int n);
    ev_t e;
    @(posedge clk);
    #1;
    n = cyc;
    data_in = d;
    cmd = c;
    strb = 1'b1;
    e.edge_n = n + 3;
    e.c = c;
    e.d = d;
    evq.push_back(e);
    $display("cycle %0d: strobe cmd=%0d data=0x%02h", n, c, d);
    repeat (4) @(posedge clk);
    #1 strb = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Model update and per-cycle comparison, sampled on the falling edge.
  initial begin : model_cmp
    ev_t ev;
    bit  have_ev;
    int  sum;
    int  lat;
    forever begin
      @(negedge clk);
      have_ev = 1'b0;
      if (evq.size() > 0 && evq[0].edge_n == cyc) begin
        ev = evq.pop_front();
        have_ev = 1'b1;
      end
      for (int d = 0; d < ND; d++) begin
        lat = LATS[d];
        if (rst) begin
          m_a[d] = 0; m_b[d] = 0; m_res[d] = 0; m_rem[d] = 0;
          m_acc[d] = 1'b0; m_drop[d] = 1'b0;
        end else if (!prev_rst && prev_ena) begin
          if (m_rem[d] > 0) begin
            if (have_ev) m_drop[d] = 1'b1;
            if (m_rem[d] == 2) begin
              sum = (m_a[d] + m_b[d]) % 256;
              m_res[d] = sum;
              if (m_acc[d]) begin
                m_a[d] = sum;
                m_acc[d] = 1'b0;
              end
            end
            m_rem[d]--;
          end else if (have_ev) begin
            case (ev.c)
              C_LDA: begin m_a[d] = int'(ev.d); m_drop[d] = 1'b0; end
              C_LDB: m_b[d] = int'(ev.d);
              C_ADD: m_rem[d] = lat + 2;
              default: begin m_b[d] = int'(ev.d); m_acc[d] = 1'b1; m_rem[d] = lat + 2; end
            endcase
          end
        end
      end
      prev_rst = rst;
      prev_ena = ena;
      for (int d = 0; d < ND; d++) begin
        lat = LATS[d];
        chk($sformatf("L%0d add_a", lat), int'(add_a_w[d]), m_a[d]);
        chk($sformatf("L%0d add_b", lat), int'(add_b_w[d]), m_b[d]);
        chk($sformatf("L%0d result", lat), int'(result_w[d]), m_res[d]);
        chk($sformatf("L%0d dropped", lat), int'(dropped_w[d]), int'(m_drop[d]));
        chk($sformatf("L%0d busy", lat), int'(busy_w[d]), int'(m_rem[d] > 0));
        chk($sformatf("L%0d add_go", lat), int'(add_go_w[d]), int'(ena && m_rem[d] == lat + 2));
        chk($sformatf("L%0d done", lat), int'(done_w[d]), int'(ena && m_rem[d] == 1));
        if (add_go_w[d]) begin go_cyc[d] = cyc; go_cnt[d]++; end
        if (done_w[d]) begin
          done_cyc[d] = cyc;
          done_cnt[d]++;
          if (d == 0) $display("cycle %0d: L1 done result=0x%02h", cyc, result_w[d]);
        end
      end
    end
  end

  initial begin : main
    int n;
    int dc;
    logic [1:0] rc;
    logic [7:0] rd;

    // Reset values and quiet release.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no add_go after reset", go_cnt[0] + go_cnt[1] + go_cnt[2], 0);
    chk("no done after reset", done_cnt[0] + done_cnt[1] + done_cnt[2], 0);

    // Basic ADD.
    issue(C_LDA, 8'h12, 0, n);
    issue(C_LDB, 8'h34, 0, n);
    issue(C_ADD, 8'h00, 12, n);
    chk("add_go 3 cycles after strobe", go_cyc[0] - n, 3);
    chk("done 2 cycles after add_go", done_cyc[0] - go_cyc[0], 2);
    chk("basic result L1", int'(result_w[0]), 'h46);
    chk("basic result L7", int'(result_w[1]), 'h46);
    chk("basic result L0", int'(result_w[2]), 'h46);

    // Accumulate chain.
    issue(C_LDA, 8'h01, 0, n);
    issue(C_ACC, 8'h02, 12, n);
    chk("acc step 1", int'(result_w[0]), 'h03);
    issue(C_ACC, 8'h03, 12, n);
    chk("acc step 2", int'(result_w[0]), 'h06);
    issue(C_ACC, 8'hFF, 12, n);
    chk("acc step 3", int'(result_w[0]), 'h05);
    chk("acc final A L1", int'(add_a_w[0]), 'h05);
    chk("acc final A L7", int'(add_a_w[1]), 'h05);

    // Strobe while busy: only the latency-7 instance is still running.
    issue(C_ADD, 8'h00, 0, n);
    issue(C_LDA, 8'h99, 12, n);
    chk("busy strobe sets dropped L7", int'(dropped_w[1]), 1);
    chk("busy strobe leaves A L7", int'(add_a_w[1]), 'h05);
    chk("idle strobe loads A L1", int'(add_a_w[0]), 'h99);
    chk("idle strobe no drop L1", int'(dropped_w[0]), 0);
    issue(C_LDA, 8'h07, 4, n);
    chk("LOAD_A clears dropped L7", int'(dropped_w[1]), 0);
    chk("LOAD_A after drop L7", int'(add_a_w[1]), 'h07);

    // Reset in the cycle after add_go.
    issue(C_LDB, 8'h10, 0, n);
    issue(C_ADD, 8'h00, 0, n);
    rst = 1'b1;
    chk("add_go before reset", go_cyc[0] - n, 3);
    dc = done_cnt[0];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no done after mid-run reset", done_cnt[0], dc);
    chk("result cleared by reset", int'(result_w[0]), 0);
    chk("idle after reset", int'(busy_w[0]), 0);

    // Enable freeze during RUN.
    issue(C_LDA, 8'h20, 0, n);
    issue(C_LDB, 8'h05, 0, n);
    issue(C_ADD, 8'h00, 0, n);
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("L7 done delayed by freeze", done_cyc[1] - go_cyc[1], 11);
    chk("L7 frozen result", int'(result_w[1]), 'h25);
    chk("L0 done next cycle", done_cyc[2] - go_cyc[2], 1);
    chk("L0 result", int'(result_w[2]), 'h25);
    chk("L1 frozen result", int'(result_w[0]), 'h25);

    // Random commands, gaps and enable pauses.
    for (int it = 0; it < 40; it++) begin
      rc = 2'($urandom_range(0, 3));
      rd = 8'($urandom_range(0, 255));
      issue(rc, rd, $urandom_range(0, 12), n);
      if ($urandom_range(0, 3) == 0) begin
        ena = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 ena = 1'b1;
      end
    end

    repeat (20) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_fp8_add_sequencer
